// File: rtl/coeff_fifo_loader.sv
// Write-side producer for the coefficient FIFO: forwards a framed host stream and appends the START marker.
// Optional running-XOR checksum output is enabled by defining COEFF_LOADER_CHECKSUM_EN.
module coeff_fifo_loader #(
   parameter int                 DATA_W     = 32,
   parameter int                 CNT_W      = 12,
   parameter logic [DATA_W-1:0]  START_WORD = 32'h7F90_0000
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              clear_i,
   input  logic              s_valid_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_last_i,
   output logic              s_ready_o,
   input  logic              fifo_full_i,
   output logic              fifo_wr_en_o,
   output logic [DATA_W-1:0] fifo_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  word_cnt_o,
   output logic              err_o
`ifdef COEFF_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum_o
`endif
);

   // state  | meaning
   // S_IDLE | no frame open; last frame's count/error held
   // S_LOAD | frame open, forwarding host words to the FIFO
   // S_MARK | waiting for a free FIFO slot to write the START marker
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MARK} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              accept, drop, wr_data, wr_mark;
`ifdef COEFF_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] chk_q, chk_d, chk_base;
`endif

   assign s_ready_o    = (state_q != S_MARK) & ~fifo_full_i & ~clear_i;
   assign accept       = s_valid_i & s_ready_o;
   assign drop         = (s_data_i == START_WORD);
   assign wr_data      = accept & ~drop;
   assign wr_mark      = (state_q == S_MARK) & ~fifo_full_i & ~clear_i;

   assign fifo_wr_en_o = wr_data | wr_mark;
   assign fifo_data_o  = (state_q == S_MARK) ? START_WORD : s_data_i;
   assign done_o       = wr_mark;
   assign busy_o       = busy_q;
   assign word_cnt_o   = cnt_q;
   assign err_o        = err_q;
`ifdef COEFF_LOADER_CHECKSUM_EN
   assign checksum_o   = chk_q;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      // The first word of a frame restarts the count from zero.
      cnt_base = (state_q == S_IDLE) ? '0 : cnt_q;
`ifdef COEFF_LOADER_CHECKSUM_EN
      chk_d    = chk_q;
      chk_base = (state_q == S_IDLE) ? '0 : chk_q;
`endif
      if (clear_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         err_d   = 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
         chk_d   = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_LOAD: begin
               if (accept) begin
                  cnt_d = cnt_base + CNT_W'(wr_data);
`ifdef COEFF_LOADER_CHECKSUM_EN
                  chk_d = wr_data ? (chk_base ^ s_data_i) : chk_base;
`endif
                  if (drop) err_d = 1'b1;
                  if (s_last_i) begin
                     state_d = S_MARK;
                  end else if (wr_data && (cnt_d == CNT_MAX)) begin
                     state_d = S_MARK;
                     err_d   = 1'b1;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
            S_MARK: begin
               if (wr_mark) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef COEFF_LOADER_CHECKSUM_EN
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
`ifdef COEFF_LOADER_CHECKSUM_EN
         chk_q   <= chk_d;
`endif
      end
   end

endmodule

// File: tb/tb_coeff_fifo_loader.sv
// Directed self-checking bench for coeff_fifo_loader (CNT_W=3 so the length limit is reachable).
module tb_coeff_fifo_loader;

   localparam int DW = 32;
   localparam int CW = 3;
   localparam logic [31:0] MK = 32'h7F90_0000;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          clear_i = 1'b0;
   logic          s_valid_i = 1'b0;
   logic [DW-1:0] s_data_i = '0;
   logic          s_last_i = 1'b0;
   logic          s_ready_o;
   logic          fifo_full_i = 1'b0;
   logic          fifo_wr_en_o;
   logic [DW-1:0] fifo_data_o;
   logic          busy_o, done_o, err_o;
   logic [CW-1:0] word_cnt_o;
`ifdef COEFF_LOADER_CHECKSUM_EN
   logic [DW-1:0] checksum_o;
`endif

   int nchk = 0;
   int npass = 0;
   logic [31:0] wq[$];

   coeff_fifo_loader #(.DATA_W(DW), .CNT_W(CW), .START_WORD(MK)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear_i),
      .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
      .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o),
      .busy_o(busy_o), .done_o(done_o), .word_cnt_o(word_cnt_o), .err_o(err_o)
`ifdef COEFF_LOADER_CHECKSUM_EN
      , .checksum_o(checksum_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i)
      if (fifo_wr_en_o) wq.push_back(fifo_data_o);

   // Called at a negedge; returns at the negedge after the word was accepted.
   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      s_valid_i = 1'b1;
      s_data_i  = d;
      s_last_i  = l;
      forever begin
         #1;
         if (s_ready_o) begin
            @(negedge clk_i);
            break;
         end
         @(negedge clk_i);
         n++;
         if (n > 50) begin
            nchk++;
            $display("FAIL send_timeout: word %h never accepted, ready=%b expected 1", d, s_ready_o);
            break;
         end
      end
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
   endtask

   // Returns at negedge+1 of the done cycle (or after budget expiry).
   task automatic wait_done(output logic seen);
      int n = 0;
      seen = 1'b0;
      while (n < 50) begin
         #1;
         if (done_o) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk_i);
         n++;
      end
      nchk++;
      if (!seen) $display("FAIL done_timeout: done_o=%b expected 1", done_o);
      else npass++;
   endtask

   task automatic test_reset();
      #1;
      nchk++; if (fifo_wr_en_o !== 1'b0) $display("FAIL rst_wr_en: got %b expected 0", fifo_wr_en_o); else npass++;
      nchk++; if (fifo_data_o !== 32'h0) $display("FAIL rst_data: got %h expected 00000000", fifo_data_o); else npass++;
      nchk++; if ({busy_o, done_o, err_o} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {busy_o, done_o, err_o}); else npass++;
      nchk++; if (word_cnt_o !== 3'd0) $display("FAIL rst_cnt: got %0d expected 0", word_cnt_o); else npass++;
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_basic_frame();
      logic seen;
      logic [31:0] exp[$];
      logic ok;
      wq.delete();
      send(32'h3F80_0000, 1'b0);
      #1;
      nchk++; if (busy_o !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy_o); else npass++;
      @(negedge clk_i);
      send(32'h4000_0000, 1'b0);
      send(32'h4040_0000, 1'b1);
      wait_done(seen);
      nchk++; if (fifo_data_o !== MK) $display("FAIL basic_marker_data: got %h expected %h", fifo_data_o, MK); else npass++;
      nchk++; if (word_cnt_o !== 3'd3) $display("FAIL basic_cnt: got %0d expected 3", word_cnt_o); else npass++;
      @(negedge clk_i);
      #1;
      nchk++; if ({busy_o, done_o, err_o} !== 3'b000) $display("FAIL basic_after: busy/done/err got %b expected 000", {busy_o, done_o, err_o}); else npass++;
      nchk++; if (word_cnt_o !== 3'd3) $display("FAIL basic_cnt_hold: got %0d expected 3", word_cnt_o); else npass++;
      exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, MK};
      ok = (wq.size() == exp.size());
      if (ok) foreach (exp[i]) if (wq[i] !== exp[i]) ok = 1'b0;
      nchk++; if (!ok) $display("FAIL basic_writes: got %0d writes %p expected %p", wq.size(), wq, exp); else npass++;
      @(negedge clk_i);
   endtask

   task automatic test_full_stall();
      logic seen;
      logic [31:0] exp[$];
      logic ok;
      wq.delete();
      send(32'h0000_0011, 1'b0);
      fifo_full_i = 1'b1;
      fork
         send(32'h0000_0022, 1'b0);
         begin
            for (int k = 0; k < 3; k++) begin
               #1;
               nchk++; if ({s_ready_o, fifo_wr_en_o} !== 2'b00) $display("FAIL full_stall_%0d: ready/wr_en got %b expected 00", k, {s_ready_o, fifo_wr_en_o}); else npass++;
               @(negedge clk_i);
            end
            fifo_full_i = 1'b0;
         end
      join
      send(32'h0000_0033, 1'b0);
      send(32'h0000_0044, 1'b1);
      fifo_full_i = 1'b1;
      repeat (2) begin
         #1;
         nchk++; if ({fifo_wr_en_o, done_o} !== 2'b00) $display("FAIL full_mark_stall: wr_en/done got %b expected 00", {fifo_wr_en_o, done_o}); else npass++;
         @(negedge clk_i);
      end
      fifo_full_i = 1'b0;
      wait_done(seen);
      @(negedge clk_i);
      exp = '{32'h11, 32'h22, 32'h33, 32'h44, MK};
      ok = (wq.size() == exp.size());
      if (ok) foreach (exp[i]) if (wq[i] !== exp[i]) ok = 1'b0;
      nchk++; if (!ok) $display("FAIL full_writes: got %0d writes %p expected %p", wq.size(), wq, exp); else npass++;
      nchk++; if (word_cnt_o !== 3'd4) $display("FAIL full_cnt: got %0d expected 4", word_cnt_o); else npass++;
   endtask

   task automatic test_marker_collision();
      logic seen;
      logic [31:0] exp[$];
      logic ok;
      wq.delete();
      send(32'h3F80_0000, 1'b0);
      send(MK, 1'b0);
      #1;
      nchk++; if (err_o !== 1'b1) $display("FAIL coll_err: got %b expected 1", err_o); else npass++;
      nchk++; if (word_cnt_o !== 3'd1) $display("FAIL coll_cnt_mid: got %0d expected 1", word_cnt_o); else npass++;
      @(negedge clk_i);
      send(32'h4040_0000, 1'b1);
      wait_done(seen);
      repeat (3) @(negedge clk_i);
      #1;
      nchk++; if (err_o !== 1'b1) $display("FAIL coll_err_sticky: got %b expected 1", err_o); else npass++;
      nchk++; if (word_cnt_o !== 3'd2) $display("FAIL coll_cnt: got %0d expected 2", word_cnt_o); else npass++;
      exp = '{32'h3F80_0000, 32'h4040_0000, MK};
      ok = (wq.size() == exp.size());
      if (ok) foreach (exp[i]) if (wq[i] !== exp[i]) ok = 1'b0;
      nchk++; if (!ok) $display("FAIL coll_writes: got %0d writes %p expected %p", wq.size(), wq, exp); else npass++;
      @(negedge clk_i);
   endtask

   task automatic test_length_limit();
      logic seen;
      logic [31:0] exp[$];
      logic ok;
      rstn_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      wq.delete();
      for (int i = 1; i <= 7; i++) send(32'h100 + i, 1'b0);
      #1;
      nchk++; if (s_ready_o !== 1'b0) $display("FAIL lim_ready: got %b expected 0", s_ready_o); else npass++;
      nchk++; if (err_o !== 1'b1) $display("FAIL lim_err: got %b expected 1", err_o); else npass++;
      nchk++; if (word_cnt_o !== 3'd7) $display("FAIL lim_cnt: got %0d expected 7", word_cnt_o); else npass++;
      @(negedge clk_i);
      send(32'h108, 1'b0);
      #1;
      nchk++; if (word_cnt_o !== 3'd1) $display("FAIL lim_next_cnt: got %0d expected 1", word_cnt_o); else npass++;
      nchk++; if (busy_o !== 1'b1) $display("FAIL lim_next_busy: got %b expected 1", busy_o); else npass++;
      @(negedge clk_i);
      send(32'h109, 1'b1);
      wait_done(seen);
      nchk++; if (word_cnt_o !== 3'd2) $display("FAIL lim_next_done_cnt: got %0d expected 2", word_cnt_o); else npass++;
      @(negedge clk_i);
      exp = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, MK, 32'h108, 32'h109, MK};
      ok = (wq.size() == exp.size());
      if (ok) foreach (exp[i]) if (wq[i] !== exp[i]) ok = 1'b0;
      nchk++; if (!ok) $display("FAIL lim_writes: got %0d writes %p expected %p", wq.size(), wq, exp); else npass++;
   endtask

   task automatic test_clear_abort();
      logic seen;
      logic [31:0] exp[$];
      logic ok;
      wq.delete();
      send(32'hA1, 1'b0);
      send(32'hA2, 1'b0);
      clear_i   = 1'b1;
      s_valid_i = 1'b1;
      s_data_i  = 32'hA3;
      #1;
      nchk++; if ({s_ready_o, fifo_wr_en_o} !== 2'b00) $display("FAIL clr_block: ready/wr_en got %b expected 00", {s_ready_o, fifo_wr_en_o}); else npass++;
      @(negedge clk_i);
      clear_i   = 1'b0;
      s_valid_i = 1'b0;
      #1;
      nchk++; if ({busy_o, err_o} !== 2'b00) $display("FAIL clr_flags: busy/err got %b expected 00", {busy_o, err_o}); else npass++;
      nchk++; if (word_cnt_o !== 3'd0) $display("FAIL clr_cnt: got %0d expected 0", word_cnt_o); else npass++;
      repeat (3) @(negedge clk_i);
      nchk++; if (wq.size() != 2) $display("FAIL clr_no_marker: got %0d writes expected 2", wq.size()); else npass++;
      send(32'hA4, 1'b1);
      wait_done(seen);
      nchk++; if (word_cnt_o !== 3'd1) $display("FAIL clr_new_cnt: got %0d expected 1", word_cnt_o); else npass++;
      @(negedge clk_i);
      exp = '{32'hA1, 32'hA2, 32'hA4, MK};
      ok = (wq.size() == exp.size());
      if (ok) foreach (exp[i]) if (wq[i] !== exp[i]) ok = 1'b0;
      nchk++; if (!ok) $display("FAIL clr_writes: got %0d writes %p expected %p", wq.size(), wq, exp); else npass++;
   endtask

   task automatic test_reset_abort();
      logic seen;
      logic [31:0] exp[$];
      logic ok;
      wq.delete();
      send(32'hB1, 1'b0);
      send(MK, 1'b0);
      send(32'hB2, 1'b0);
      rstn_i = 1'b0;
      #1;
      nchk++; if ({busy_o, err_o} !== 2'b00) $display("FAIL rstab_flags: busy/err got %b expected 00", {busy_o, err_o}); else npass++;
      nchk++; if (word_cnt_o !== 3'd0) $display("FAIL rstab_cnt: got %0d expected 0", word_cnt_o); else npass++;
      @(negedge clk_i);
      rstn_i = 1'b1;
      repeat (3) @(negedge clk_i);
      nchk++; if (wq.size() != 2) $display("FAIL rstab_no_marker: got %0d writes expected 2", wq.size()); else npass++;
      send(32'hB3, 1'b1);
      wait_done(seen);
      nchk++; if (word_cnt_o !== 3'd1) $display("FAIL rstab_new_cnt: got %0d expected 1", word_cnt_o); else npass++;
      @(negedge clk_i);
      exp = '{32'hB1, 32'hB2, 32'hB3, MK};
      ok = (wq.size() == exp.size());
      if (ok) foreach (exp[i]) if (wq[i] !== exp[i]) ok = 1'b0;
      nchk++; if (!ok) $display("FAIL rstab_writes: got %0d writes %p expected %p", wq.size(), wq, exp); else npass++;
   endtask

`ifdef COEFF_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic seen;
      send(32'h0000_0001, 1'b0);
      send(32'h0000_0003, 1'b1);
      wait_done(seen);
      nchk++; if (checksum_o !== 32'h0000_0002) $display("FAIL chk_value: got %h expected 00000002", checksum_o); else npass++;
      @(negedge clk_i);
      #1;
      nchk++; if (checksum_o !== 32'h0000_0002) $display("FAIL chk_hold: got %h expected 00000002", checksum_o); else npass++;
      @(negedge clk_i);
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_full_stall();
      test_marker_collision();
      test_length_limit();
      test_clear_abort();
      test_reset_abort();
`ifdef COEFF_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
